mem_port_arbiter: RTL and testbench

//  Shares the single-port synchronous data/instruction memory between the multicycle CPU
//  (fetch/load/store) and the debug/loader port. The CPU control FSM raises cpu_req instead
//  of driving MemRead/MemWrite directly and waits on cpu_gnt/cpu_rvalid; the loader uses dbg_*.

---
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared single-port memory between the CPU and the debug/loader port.
// Optional MEM_ARB_LOCK_EN adds dbg_lock, which gives the loader exclusive ownership.
`timescale 1ns/1ps

// state   | meaning
// S_IDLE  | bus free; arbitrate and latch the winning command
// S_ACC   | command on the memory bus, owner's gnt high
// S_RD_WAIT | memory returns read data; captured into the owner's rdata
module mem_port_arbiter #(
   parameter int ADDR_W     = 8,
   parameter int DATA_W     = 8,
   parameter int STARVE_MAX = 4
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_gnt,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              dbg_req,
   input  logic              dbg_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_gnt,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
`ifdef MEM_ARB_LOCK_EN
   input  logic              dbg_lock,
`endif
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_re,
   output logic              mem_we,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ACC     = 2'd1,
      S_RD_WAIT = 2'd2
   } state_t;

   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   state_t              state_q;
   logic                owner_q;
   logic                we_q;
   logic [3:0]          starve_q;
   logic [3:0]          starve_d;
   logic                cpu_gnt_q;
   logic                dbg_gnt_q;
   logic                cpu_rvalid_q;
   logic                dbg_rvalid_q;
   logic [DATA_W-1:0]   cpu_rdata_q;
   logic [DATA_W-1:0]   dbg_rdata_q;
   logic [ADDR_W-1:0]   mem_addr_q;
   logic [DATA_W-1:0]   mem_wdata_q;
   logic                mem_re_q;
   logic                mem_we_q;

   logic                cpu_win;
   logic                dbg_win;
   logic                sel_we;
   logic [ADDR_W-1:0]   sel_addr;
   logic [DATA_W-1:0]   sel_wdata;

   assign cpu_gnt    = cpu_gnt_q;
   assign dbg_gnt    = dbg_gnt_q;
   assign cpu_rvalid = cpu_rvalid_q;
   assign dbg_rvalid = dbg_rvalid_q;
   assign cpu_rdata  = cpu_rdata_q;
   assign dbg_rdata  = dbg_rdata_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_re     = mem_re_q;
   assign mem_we     = mem_we_q;

   // The count can only reach STARVE_LIM on a lost contest, and at the limit dbg wins,
   // so the increment below never overflows past the limit.
   always_comb begin
      cpu_win  = 1'b0;
      dbg_win  = 1'b0;
      starve_d = starve_q;
      if (state_q == S_IDLE) begin
`ifdef MEM_ARB_LOCK_EN
         if (dbg_lock) begin
            dbg_win  = dbg_req;
            starve_d = '0;
         end else
`endif
         if (dbg_req && (!cpu_req || starve_q == STARVE_LIM)) begin
            dbg_win  = 1'b1;
            starve_d = '0;
         end else if (cpu_req) begin
            cpu_win  = 1'b1;
            starve_d = dbg_req ? starve_q + 4'd1 : 4'd0;
         end else begin
            starve_d = '0;
         end
      end
      sel_we    = dbg_win ? dbg_we    : cpu_we;
      sel_addr  = dbg_win ? dbg_addr  : cpu_addr;
      sel_wdata = dbg_win ? dbg_wdata : cpu_wdata;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state_q      <= S_IDLE;
         owner_q      <= 1'b0;
         we_q         <= 1'b0;
         starve_q     <= '0;
         cpu_gnt_q    <= 1'b0;
         dbg_gnt_q    <= 1'b0;
         cpu_rvalid_q <= 1'b0;
         dbg_rvalid_q <= 1'b0;
         cpu_rdata_q  <= '0;
         dbg_rdata_q  <= '0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         mem_re_q     <= 1'b0;
         mem_we_q     <= 1'b0;
      end else begin
         starve_q     <= starve_d;
         cpu_gnt_q    <= 1'b0;
         dbg_gnt_q    <= 1'b0;
         cpu_rvalid_q <= 1'b0;
         dbg_rvalid_q <= 1'b0;
         mem_re_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (cpu_win || dbg_win) begin
                  owner_q     <= dbg_win;
                  we_q        <= sel_we;
                  mem_addr_q  <= sel_addr;
                  mem_wdata_q <= sel_wdata;
                  mem_re_q    <= ~sel_we;
                  mem_we_q    <= sel_we;
                  cpu_gnt_q   <= cpu_win;
                  dbg_gnt_q   <= dbg_win;
                  state_q     <= S_ACC;
               end
            end
            S_ACC: begin
               state_q <= we_q ? S_IDLE : S_RD_WAIT;
            end
            S_RD_WAIT: begin
               if (owner_q) begin
                  dbg_rdata_q  <= mem_rdata;
                  dbg_rvalid_q <= 1'b1;
               end else begin
                  cpu_rdata_q  <= mem_rdata;
                  cpu_rvalid_q <= 1'b1;
               end
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, multi-cycle arbitration sequences,
// and random traffic against a transaction-schedule reference model.
`timescale 1ns/1ps

module tb_mem_port_arbiter;

   localparam int AW   = 8;
   localparam int DW   = 8;
   localparam int SMAX = 4;

   logic          clock = 1'b0;
   logic          resetn;
   logic          cpu_req, cpu_we, dbg_req, dbg_we;
   logic [AW-1:0] cpu_addr, dbg_addr;
   logic [DW-1:0] cpu_wdata, dbg_wdata;
   logic          cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
   logic [DW-1:0] cpu_rdata, dbg_rdata;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata, mem_rdata;
   logic          mem_re, mem_we;
`ifdef MEM_ARB_LOCK_EN
   logic          dbg_lock;
`endif

   always #5 clock = ~clock;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
      .clock(clock), .resetn(resetn),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
`ifdef MEM_ARB_LOCK_EN
      .dbg_lock(dbg_lock),
`endif
      .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_re(mem_re), .mem_we(mem_we),
      .mem_rdata(mem_rdata)
   );

   function automatic logic [7:0] pattern(input int sel, input int i);
      if (sel == 0) return (i == 16) ? 8'hA5 : 8'h00;
      return 8'(i * 7 + 3);
   endfunction

   // Memory behind the arbiter: read data appears the cycle after mem_re.
   logic [7:0] env_mem [256];
   logic       init_mem = 1'b0;
   int         pat_sel  = 0;
   always @(posedge clock) begin
      if (init_mem) begin
         for (int i = 0; i < 256; i++) env_mem[i] <= pattern(pat_sel, i);
      end else if (mem_we) begin
         env_mem[mem_addr] <= mem_wdata;
      end
      if (mem_re) mem_rdata <= env_mem[mem_addr];
   end

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   typedef struct {
      bit         port;
      bit         we;
      logic [7:0] addr;
      logic [7:0] wdata;
      logic [7:0] exp_rdata;
   } vec_t;
   vec_t vecs [8];

   typedef struct {
      bit         cg, dg, re, we, cv, dv;
      logic [7:0] addr, wdata, rdata;
   } ev_t;
   ev_t ring [8];

   logic [7:0] m_cpu_rd, m_dbg_rd;
   logic [7:0] shadow [256];
   int         free_at, m_starve, n1, n3;
   bit         w_dbg, w_any, w_we, cg_seen, dg_seen, both_seen, rv_seen;
   logic [7:0] w_addr, w_wdata;
   logic [31:0] seq;
   int         got;
   ev_t        s;

   task automatic reset_dut();
      resetn = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
`ifdef MEM_ARB_LOCK_EN
      dbg_lock = 1'b0;
`endif
      m_cpu_rd = '0;
      m_dbg_rd = '0;
      repeat (2) @(posedge clock);
      #1 resetn = 1'b1;
   endtask

   // Called just after a rising edge with the DUT idle; returns likewise.
   task automatic run_vec(input vec_t v);
      if (v.port) begin
         dbg_req = 1'b1; dbg_we = v.we; dbg_addr = v.addr; dbg_wdata = v.wdata;
      end else begin
         cpu_req = 1'b1; cpu_we = v.we; cpu_addr = v.addr; cpu_wdata = v.wdata;
      end
      @(negedge clock);
      chk("vec_no_early_gnt", 64'({cpu_gnt, dbg_gnt}), 64'(2'b00));
      @(posedge clock); #1;
      @(negedge clock);
      chk("vec_gnt_strobe", 64'({cpu_gnt, dbg_gnt, mem_re, mem_we}),
          64'({~v.port, v.port, ~v.we, v.we}));
      chk("vec_mem_cmd", 64'({mem_addr, v.we ? mem_wdata : 8'h00}),
          64'({v.addr, v.we ? v.wdata : 8'h00}));
      @(posedge clock); #1;
      cpu_req = 1'b0;
      dbg_req = 1'b0;
      @(negedge clock);
      chk("vec_t2_quiet", 64'({cpu_gnt, dbg_gnt, mem_re, mem_we, cpu_rvalid, dbg_rvalid}), 64'(0));
      @(posedge clock); #1;
      @(negedge clock);
      if (!v.we) begin
         if (v.port) m_dbg_rd = v.exp_rdata;
         else        m_cpu_rd = v.exp_rdata;
      end
      chk("vec_rvalid", 64'({cpu_rvalid, dbg_rvalid}), v.we ? 64'(0) : 64'({~v.port, v.port}));
      chk("vec_rdata", 64'({cpu_rdata, dbg_rdata}), 64'({m_cpu_rd, m_dbg_rd}));
      @(posedge clock); #1;
   endtask

   // Records the owner of the next n grants (bit = 1 for dbg) within a cycle budget.
   task automatic collect(input int n, input int budget, output logic [31:0] sq, output int g);
      sq = '0;
      g  = 0;
      for (int c = 0; c < budget && g < n; c++) begin
         @(negedge clock);
         if (cpu_gnt && dbg_gnt) both_seen = 1'b1;
         if (cpu_gnt || dbg_gnt) begin
            sq[g] = dbg_gnt;
            g++;
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{1'b0, 1'b0, 8'h10, 8'h00, 8'hA5};
      vecs[1] = '{1'b1, 1'b1, 8'h20, 8'h3C, 8'h00};
      vecs[2] = '{1'b0, 1'b0, 8'h20, 8'h00, 8'h3C};
      vecs[3] = '{1'b1, 1'b0, 8'h10, 8'h00, 8'hA5};
      vecs[4] = '{1'b0, 1'b1, 8'hFF, 8'h5A, 8'h00};
      vecs[5] = '{1'b1, 1'b0, 8'hFF, 8'h00, 8'h5A};
      vecs[6] = '{1'b0, 1'b0, 8'h00, 8'h00, 8'h00};
      vecs[7] = '{1'b1, 1'b1, 8'h00, 8'hC3, 8'h00};

      resetn = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
`ifdef MEM_ARB_LOCK_EN
      dbg_lock = 1'b0;
`endif
      pat_sel  = 0;
      init_mem = 1'b1;
      @(posedge clock); #1 init_mem = 1'b0;
      @(posedge clock);
      @(negedge clock);
      chk("reset_state", 64'({cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_re, mem_we,
                              mem_addr, mem_wdata, cpu_rdata, dbg_rdata}), 64'(0));
      @(posedge clock); #1 resetn = 1'b1;
      m_cpu_rd = '0;
      m_dbg_rd = '0;

      for (int i = 0; i < 8; i++) run_vec(vecs[i]);

      // Both ports reading continuously: CPU wins four, then dbg once.
      reset_dut();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h20;
      both_seen = 1'b0;
      collect(15, 100, seq, got);
      chk("s3_grant_count", 64'(got), 64'(15));
      chk("s3_grant_order", 64'(seq), 64'(32'h0000_4210));
      chk("s3_no_dual_gnt", 64'(both_seen), 64'(0));

      // One lost contest, then dbg_req absent at the next arbitration clears the count.
      reset_dut();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h20;
      both_seen = 1'b0;
      collect(1, 10, seq, got);
      chk("s4_first_owner", 64'({got[3:0], seq[0]}), 64'({4'd1, 1'b0}));
      @(posedge clock); #1 dbg_req = 1'b0;
      collect(1, 10, seq, got);
      chk("s4_cpu_alone", 64'({got[3:0], seq[0]}), 64'({4'd1, 1'b0}));
      @(posedge clock); #1 dbg_req = 1'b1;
      collect(5, 40, seq, got);
      chk("s4_count_cleared", 64'({got[7:0], seq[7:0]}), 64'({8'd5, 8'h10}));
      chk("s4_no_dual_gnt", 64'(both_seen), 64'(0));

      // Reset while a CPU read is in RD_WAIT: everything clears and no rvalid follows.
      reset_dut();
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
      @(posedge clock); #1;
      @(posedge clock); #1;
      cpu_req = 1'b0;
      resetn  = 1'b0;
      #1;
      chk("s5_reset_outputs", 64'({cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_re, mem_we,
                                   mem_addr, mem_wdata, cpu_rdata, dbg_rdata}), 64'(0));
      repeat (2) @(posedge clock);
      #1 resetn = 1'b1;
      m_cpu_rd = '0;
      m_dbg_rd = '0;
      rv_seen = 1'b0;
      repeat (6) begin
         @(negedge clock);
         if (cpu_rvalid || dbg_rvalid) rv_seen = 1'b1;
      end
      chk("s5_no_stale_rvalid", 64'(rv_seen), 64'(0));
      @(posedge clock); #1;
      run_vec(vecs[0]);

`ifdef MEM_ARB_LOCK_EN
      reset_dut();
      dbg_lock = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h20;
      both_seen = 1'b0;
      collect(10, 60, seq, got);
      chk("s6_lock_grants", 64'({got[7:0], seq[15:0]}), 64'({8'd10, 16'h03FF}));
      @(posedge clock); #1 dbg_lock = 1'b0;
      collect(1, 10, seq, got);
      chk("s6_unlock_cpu", 64'({got[3:0], seq[0]}), 64'({4'd1, 1'b0}));
`endif

      // Random traffic against a schedule of expected bus events.
      resetn   = 1'b0;
      pat_sel  = 1;
      init_mem = 1'b1;
      @(posedge clock); #1 init_mem = 1'b0;
      reset_dut();
      for (int i = 0; i < 256; i++) shadow[i] = pattern(1, i);
      for (int i = 0; i < 8; i++) ring[i] = '{default: '0};
      free_at  = 0;
      m_starve = 0;
      cg_seen  = 1'b0;
      dg_seen  = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(posedge clock); #1;
         if (cg_seen) cpu_req = 1'b0;
         else if (!cpu_req && $urandom_range(3) != 0) begin
            cpu_req = 1'b1; cpu_we = 1'($urandom_range(1));
            cpu_addr = 8'($urandom); cpu_wdata = 8'($urandom);
         end
         if (dg_seen) dbg_req = 1'b0;
         else if (!dbg_req && $urandom_range(1) != 0) begin
            dbg_req = 1'b1; dbg_we = 1'($urandom_range(1));
            dbg_addr = 8'($urandom); dbg_wdata = 8'($urandom);
         end
         @(negedge clock);
         s = ring[cyc % 8];
         if (s.cv) m_cpu_rd = s.rdata;
         if (s.dv) m_dbg_rd = s.rdata;
         chk("rnd_cycle", 64'({cpu_gnt, dbg_gnt, mem_re, mem_we, cpu_rvalid, dbg_rvalid,
                               cpu_rdata, dbg_rdata}),
             64'({s.cg, s.dg, s.re, s.we, s.cv, s.dv, m_cpu_rd, m_dbg_rd}));
         if (s.cg || s.dg)
            chk("rnd_cmd", 64'({mem_addr, s.we ? mem_wdata : 8'h00}),
                64'({s.addr, s.we ? s.wdata : 8'h00}));
         ring[cyc % 8] = '{default: '0};
         cg_seen = cpu_gnt;
         dg_seen = dbg_gnt;
         if (cyc >= free_at) begin
            w_any = 1'b1;
            w_dbg = 1'b0;
            if (cpu_req && dbg_req) begin
               if (m_starve == SMAX) begin w_dbg = 1'b1; m_starve = 0; end
               else m_starve++;
            end else if (dbg_req) begin
               w_dbg = 1'b1; m_starve = 0;
            end else if (cpu_req) begin
               m_starve = 0;
            end else begin
               w_any = 1'b0; m_starve = 0;
            end
            if (w_any) begin
               w_we    = w_dbg ? dbg_we    : cpu_we;
               w_addr  = w_dbg ? dbg_addr  : cpu_addr;
               w_wdata = w_dbg ? dbg_wdata : cpu_wdata;
               n1 = (cyc + 1) % 8;
               ring[n1].cg = !w_dbg;  ring[n1].dg = w_dbg;
               ring[n1].re = !w_we;   ring[n1].we = w_we;
               ring[n1].addr = w_addr; ring[n1].wdata = w_wdata;
               if (w_we) begin
                  shadow[w_addr] = w_wdata;
                  free_at = cyc + 2;
               end else begin
                  n3 = (cyc + 3) % 8;
                  ring[n3].cv = !w_dbg; ring[n3].dv = w_dbg;
                  ring[n3].rdata = shadow[w_addr];
                  free_at = cyc + 3;
               end
            end
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
